// File: rtl/screen_sequence_checker.sv
// screen_sequence_checker: four-step screen code defusal FSM with countdown timer.
// Optional feature: define SCREEN_CHECK_STRIKES_EN to tolerate two wrong presses
// (third strike explodes) and expose the strike count on port strikes.
module screen_sequence_checker #(
    parameter int TIMEOUT = 1000,
    parameter int TIMER_W = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               start,
    input  logic [1:0]         first,
    input  logic [1:0]         second,
    input  logic [1:0]         third,
    input  logic [1:0]         fourth,
    input  logic               press_valid,
    input  logic [1:0]         press_code,
    output logic               busy,
    output logic [2:0]         step,
    output logic               defused,
    output logic               exploded,
    output logic [TIMER_W-1:0] time_left
`ifdef SCREEN_CHECK_STRIKES_EN
    ,
    output logic [1:0]         strikes
`endif
);

    typedef enum logic [1:0] {IDLE, ARMED, DEFUSED, EXPLODED} state_t;

    state_t            state;
    logic [3:0][1:0]   codes;
    logic [TIMER_W-1:0] t_dec;
    logic              hit;

    // Saturating decrement and match against the latched code for the current step
    always_comb begin
        t_dec = (time_left == '0) ? '0 : time_left - TIMER_W'(1);
        hit   = press_valid && (press_code == codes[step[1:0]]);
    end

    // Main FSM; every output is a register updated alongside the state
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            codes     <= '0;
            busy      <= 1'b0;
            step      <= 3'd0;
            defused   <= 1'b0;
            exploded  <= 1'b0;
            time_left <= '0;
`ifdef SCREEN_CHECK_STRIKES_EN
            strikes   <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE, DEFUSED, EXPLODED: begin
                    if (start) begin
                        state     <= ARMED;
                        codes     <= {fourth, third, second, first};
                        busy      <= 1'b1;
                        step      <= 3'd0;
                        defused   <= 1'b0;
                        exploded  <= 1'b0;
                        time_left <= TIMEOUT[TIMER_W-1:0];
`ifdef SCREEN_CHECK_STRIKES_EN
                        strikes   <= 2'd0;
`endif
                    end
                end
                ARMED: begin
                    if (hit) begin
                        step <= step + 3'd1;
                        if (step == 3'd3) begin
                            state   <= DEFUSED;
                            busy    <= 1'b0;
                            defused <= 1'b1;
                        end else begin
                            time_left <= t_dec;
                        end
                    end else if (press_valid) begin
`ifdef SCREEN_CHECK_STRIKES_EN
                        strikes <= strikes + 2'd1;
                        if (strikes == 2'd2) begin
                            state    <= EXPLODED;
                            busy     <= 1'b0;
                            exploded <= 1'b1;
                        end else begin
                            time_left <= t_dec;
                        end
`else
                        state    <= EXPLODED;
                        busy     <= 1'b0;
                        exploded <= 1'b1;
`endif
                    end else if (time_left <= TIMER_W'(1)) begin
                        // A press landing on the last cycle may leave time_left at 0;
                        // the next press-free cycle still explodes
                        state     <= EXPLODED;
                        busy      <= 1'b0;
                        exploded  <= 1'b1;
                        time_left <= '0;
                    end else begin
                        time_left <= t_dec;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/screen_sequence_checker.md
SCREEN_SEQUENCE_CHECKER -- requirements
Module: screen_sequence_checker

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1000, giving the cycles allowed in ARMED before explosion (legal range 1 to 2^TIMER_W-1).
REQ-002 The block SHALL have parameter TIMER_W, default 16, giving the width of the countdown timer.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: arm request; it latches the screen codes.
REQ-006 The block SHALL have ports first, second, third and fourth, inputs, 2 bits each: the expected screen codes for steps 0 to 3, in order.
REQ-007 The block SHALL have port press_valid, input, 1 bit: one-cycle strobe marking a player press.
REQ-008 The block SHALL have port press_code, input, 2 bits: the screen code the player pressed, qualified by press_valid.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in state ARMED.
REQ-010 The block SHALL have port step, output, 3 bits: the number of correct presses so far (0 to 4).
REQ-011 The block SHALL have port defused, output, 1 bit: high while in state DEFUSED.
REQ-012 The block SHALL have port exploded, output, 1 bit: high while in state EXPLODED.
REQ-013 The block SHALL have port time_left, output, TIMER_W bits: the current countdown value.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ARMED, DEFUSED and EXPLODED.
REQ-015 All outputs SHALL be registered; a state change SHALL be visible on the cycle after the causing edge.
REQ-016 In IDLE, DEFUSED or EXPLODED, start=1 SHALL do all of the following on that edge: latch first..fourth, set step=0, load time_left=TIMEOUT, and enter ARMED.
REQ-017 In ARMED, start SHALL be ignored, and changes on first..fourth SHALL have no effect; the block compares only against the latched copies.
REQ-018 In ARMED with press_valid=1 and press_code equal to the latched code at index step, the block SHALL increment step.
REQ-019 If that matching press has step==3, step SHALL become 4 and the FSM SHALL enter DEFUSED.
REQ-020 In ARMED with press_valid=1 and a mismatching press_code, the block SHALL perform the mismatch action defined in REQ-032.
REQ-021 In ARMED, time_left SHALL decrement by 1 on every cycle in which no terminal transition occurs.
REQ-022 In ARMED, when time_left==1 and no press is valid on that edge, the FSM SHALL enter EXPLODED with time_left=0.
REQ-023 A valid press and timer expiry on the same edge SHALL be resolved with the press taking priority: a match advances or defuses, and a mismatch follows REQ-032.
REQ-024 time_left SHALL never wrap below 0.
REQ-025 DEFUSED and EXPLODED SHALL hold step and time_left frozen until start or Rst.
REQ-026 press_valid outside ARMED SHALL be ignored.
REQ-027 Repeated identical codes (e.g. first==second) SHALL be legal; each press is checked independently.

Reset
REQ-028 Rst=1 SHALL force state=IDLE on the next edge, regardless of state, including mid-sequence in ARMED.
REQ-029 Rst=1 SHALL force busy=0, defused=0, exploded=0, step=0 and time_left=0, and clear the latched codes and the strike count to 0.
REQ-030 Rst SHALL take priority over start and press_valid on the same edge.

Configuration
REQ-031 The feature SHALL be selected by macro SCREEN_CHECK_STRIKES_EN.
REQ-032 The mismatch action SHALL be:
  - without SCREEN_CHECK_STRIKES_EN: any mismatch in ARMED sends the FSM directly to EXPLODED;
  - with SCREEN_CHECK_STRIKES_EN: a 2-bit strike counter (cleared on arm) increments on each mismatch, step is unchanged, and the third mismatch enters EXPLODED.
REQ-033 With SCREEN_CHECK_STRIKES_EN, an additional output port strikes, 2 bits, SHALL present the strike count; the port SHALL be absent without the macro.
REQ-034 Timer behaviour SHALL be identical in both builds.

Verification
REQ-035 Bench SHALL cover: Rst then start with codes 01,00,10,11, then presses 01,00,10,11 -> step 1,2,3,4; defused=1, busy=0 after the 4th press.
REQ-036 Bench SHALL cover: armed with TIMEOUT=8 and no presses -> time_left 8..1, then exploded=1 with time_left=0 exactly 8 cycles after arm.
REQ-037 Bench SHALL cover: codes 10,00,01,11 with presses 10 then 11 -> macro off: exploded=1 with step=1; macro on: strikes=1, step=1, busy=1.
REQ-038 Bench SHALL cover: a correct press on the cycle time_left==1 -> step increments, no explosion; a later timeout still explodes.
REQ-039 Bench SHALL cover: Rst asserted at step=2 in ARMED -> next cycle IDLE with all outputs 0; press_valid then ignored.
REQ-040 Bench SHALL cover: first..fourth changed mid-ARMED -> the original latched sequence still defuses; start in DEFUSED re-arms with the new codes.
